// File: rtl/sysop_seq_pkg.sv
// sysop_seq_pkg: SYSOP codes, sequencer state encoding and op helpers shared by the CSR/trap path
package sysop_seq_pkg;
   localparam logic [4:0] SYSOP_NONE = 5'h00;
   localparam logic [4:0] SYSOP_CSRW = 5'h01;
   localparam logic [4:0] SYSOP_CSRS = 5'h02;
   localparam logic [4:0] SYSOP_CSRC = 5'h03;
   localparam logic [4:0] SYSOP_MRET = 5'h04;
   localparam logic [4:0] SYSOP_SRET = 5'h05;
   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ISSUE, ST_RESP} sysop_state_e;
   function automatic logic is_except(input logic [4:0] op);
      return op[4];
   endfunction
endpackage

// File: rtl/sysop_seq.sv
// sysop_seq: serialises one system request at a time: drain older work, issue once to csr, return writeback/redirect
module sysop_seq
   import sysop_seq_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [63:0] req_pc,
   input  logic [63:0] req_tval,
   input  logic [63:0] req_wdata,
   input  logic [4:0]  req_rd,
   input  logic        pipe_busy,
   output logic [4:0]  csr_op,
   output logic [63:0] csr_pc,
   output logic [63:0] csr_tval,
   output logic [63:0] csr_wdata,
   input  logic [63:0] csr_rdata,
   input  logic        csr_r_valid,
   input  logic        csr_trap_en,
   input  logic [63:0] csr_trap_pc,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic        drain_err
);
   localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
   sysop_state_e state, state_nx;
   logic [CW-1:0] cnt;
   logic [4:0]    op_q, rd_q;
   logic [63:0]   pc_q, tval_q, wdata_q, rdata_q, tpc_q;
   logic          rv_q, te_q;
   logic          accept, timeout;
   assign accept  = state == ST_IDLE && req_valid;
   // the increment that would reach DRAIN_TIMEOUT forces issue instead
   assign timeout = state == ST_DRAIN && pipe_busy && cnt == CW'(DRAIN_TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state == ST_IDLE  ? (req_valid ? ST_DRAIN : ST_IDLE) :
                 state == ST_DRAIN ? ((!pipe_busy || timeout) ? ST_ISSUE : ST_DRAIN) :
                 state == ST_ISSUE ? ST_RESP : ST_IDLE;
      req_ready      = state == ST_IDLE;
      busy           = state != ST_IDLE;
      csr_op         = state == ST_ISSUE ? op_q    : SYSOP_NONE;
      csr_pc         = state == ST_ISSUE ? pc_q    : '0;
      csr_tval       = state == ST_ISSUE ? tval_q  : '0;
      csr_wdata      = state == ST_ISSUE ? wdata_q : '0;
      wb_valid       = state == ST_RESP && rv_q && rd_q != '0;
      wb_rd          = wb_valid ? rd_q : '0;
      wb_data        = wb_valid ? rdata_q : '0;
      redirect_valid = state == ST_RESP && te_q;
      redirect_pc    = redirect_valid ? tpc_q : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt       <= '0;
         op_q      <= SYSOP_NONE;
         pc_q      <= '0;
         tval_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         rdata_q   <= '0;
         rv_q      <= 1'b0;
         te_q      <= 1'b0;
         tpc_q     <= '0;
         drain_err <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= '0;
            op_q    <= req_op;
            pc_q    <= req_pc;
            tval_q  <= req_tval;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
         end else if (state == ST_DRAIN && pipe_busy) begin
            cnt <= cnt + 1'b1;
         end
         if (state == ST_ISSUE) begin
            rdata_q <= csr_rdata;
            rv_q    <= csr_r_valid;
            te_q    <= csr_trap_en;
            tpc_q   <= csr_trap_pc;
         end
         if (timeout) drain_err <= 1'b1;
      end
endmodule

// File: tb/tb_sysop_seq.sv
// tb_sysop_seq: table vectors, reset corner cases and random requests against a request-level model
module tb_sysop_seq;
   import sysop_seq_pkg::*;
   localparam int T = 4;
   logic        clk, rst_n, req_valid, req_ready, pipe_busy;
   logic [4:0]  req_op, req_rd, csr_op, wb_rd;
   logic [63:0] req_pc, req_tval, req_wdata, csr_pc, csr_tval, csr_wdata;
   logic [63:0] csr_rdata, csr_trap_pc, wb_data, redirect_pc;
   logic        csr_r_valid, csr_trap_en, busy, wb_valid, redirect_valid, drain_err;
   int n_cmp = 0, n_bad = 0;
   logic exp_err = 1'b0;
   typedef struct {
      logic [4:0]  op;
      logic [63:0] pc, tval, wdata;
      logic [4:0]  rd;
      int          nb;
      logic [63:0] rdata;
      logic        rv, te;
      logic [63:0] tpc;
   } vec_t;
   vec_t tbl[7];
   vec_t v;
   sysop_seq #(.DRAIN_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_pc(req_pc), .req_tval(req_tval), .req_wdata(req_wdata),
      .req_rd(req_rd), .pipe_busy(pipe_busy), .csr_op(csr_op), .csr_pc(csr_pc),
      .csr_tval(csr_tval), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .csr_r_valid(csr_r_valid), .csr_trap_en(csr_trap_en), .csr_trap_pc(csr_trap_pc),
      .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .drain_err(drain_err)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask
   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {63'b0, act}, {63'b0, exp});
   endtask
   task automatic noise();
      csr_rdata   = {$urandom, $urandom};
      csr_r_valid = 1'($urandom);
      csr_trap_en = 1'($urandom);
      csr_trap_pc = {$urandom, $urandom};
   endtask
   task automatic idle_checks(input string tag);
      chk1({tag, "_ready"}, req_ready, 1'b1);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_op"}, {59'b0, csr_op}, 64'h0);
      chk1({tag, "_wb"}, wb_valid, 1'b0);
      chk1({tag, "_redir"}, redirect_valid, 1'b0);
      chk({tag, "_wbdata"}, wb_data, 64'h0);
      chk({tag, "_rpc"}, redirect_pc, 64'h0);
      chk1({tag, "_derr"}, drain_err, exp_err);
   endtask
   // model: drain lasts one cycle past the busy run, capped at T cycles (cap sets sticky error)
   task automatic run_req(input vec_t r);
      int  len;
      logic exp_wb;
      len = r.nb < T ? r.nb + 1 : T;
      idle_checks("idle");
      req_valid = 1'b1;
      req_op = r.op; req_pc = r.pc; req_tval = r.tval; req_wdata = r.wdata; req_rd = r.rd;
      pipe_busy = 1'($urandom);
      noise();
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_op = 5'($urandom); req_pc = {$urandom, $urandom}; req_rd = 5'($urandom);
         pipe_busy = k <= r.nb;
         noise();
         chk1("drain_busy", busy, 1'b1);
         chk1("drain_ready", req_ready, 1'b0);
         chk("drain_op", {59'b0, csr_op}, 64'h0);
         chk1("drain_wb", wb_valid, 1'b0);
         chk1("drain_redir", redirect_valid, 1'b0);
      end
      if (r.nb >= T) exp_err = 1'b1;
      @(negedge clk);
      pipe_busy = 1'($urandom);
      csr_rdata = r.rdata; csr_r_valid = r.rv; csr_trap_en = r.te; csr_trap_pc = r.tpc;
      chk("issue_op", {59'b0, csr_op}, {59'b0, r.op});
      chk("issue_pc", csr_pc, r.pc);
      chk("issue_tval", csr_tval, r.tval);
      chk("issue_wdata", csr_wdata, r.wdata);
      chk1("issue_busy", busy, 1'b1);
      chk1("issue_derr", drain_err, exp_err);
      chk1("issue_wb", wb_valid, 1'b0);
      @(negedge clk);
      noise();
      exp_wb = r.rv && r.rd != 5'd0;
      chk1("resp_wb", wb_valid, exp_wb);
      chk("resp_wbdata", wb_data, exp_wb ? r.rdata : 64'h0);
      if (exp_wb) chk("resp_wbrd", {59'b0, wb_rd}, {59'b0, r.rd});
      chk1("resp_redir", redirect_valid, r.te);
      chk("resp_rpc", redirect_pc, r.te ? r.tpc : 64'h0);
      chk("resp_op", {59'b0, csr_op}, 64'h0);
      chk1("resp_ready", req_ready, 1'b0);
      @(negedge clk);
      idle_checks("after");
   endtask
   initial begin
      tbl[0] = '{SYSOP_CSRW, 64'h100, 64'h300, 64'h8, 5'd5, 0, 64'h1800, 1'b1, 1'b0, 64'h0};
      tbl[1] = '{5'h18, 64'h80001000, 64'hdead, 64'h0, 5'd0, 3, 64'h0, 1'b0, 1'b1, 64'h80000100};
      tbl[2] = '{SYSOP_CSRS, 64'h200, 64'h300, 64'h4, 5'd0, 1, 64'h55, 1'b1, 1'b0, 64'h0};
      tbl[3] = '{SYSOP_CSRS, 64'h1000, 64'h180, 64'h0, 5'd10, 0, 64'hABC, 1'b1, 1'b1, 64'h1004};
      tbl[4] = '{SYSOP_NONE, 64'h300, 64'h0, 64'h0, 5'd7, 2, 64'h0, 1'b0, 1'b0, 64'h0};
      tbl[5] = '{SYSOP_CSRC, 64'h400, 64'h340, 64'h1, 5'd3, 9, 64'h77, 1'b1, 1'b0, 64'h0};
      tbl[6] = '{SYSOP_MRET, 64'h500, 64'h0, 64'h0, 5'd0, 0, 64'h0, 1'b0, 1'b1, 64'h2000};
      rst_n = 1'b0; req_valid = 1'b0; pipe_busy = 1'b0;
      req_op = '0; req_pc = '0; req_tval = '0; req_wdata = '0; req_rd = '0;
      noise();
      @(negedge clk);
      idle_checks("reset");
      chk("reset_cpc", csr_pc, 64'h0);
      chk("reset_ctval", csr_tval, 64'h0);
      chk("reset_cwdata", csr_wdata, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 7; i++) run_req(tbl[i]);
      // reset while draining: error flag and pending request both dropped
      req_valid = 1'b1; req_op = SYSOP_CSRW; req_pc = 64'h600; req_rd = 5'd4; pipe_busy = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk1("rdrain_busy_pre", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      exp_err = 1'b0;
      idle_checks("rst_drain");
      #1 rst_n = 1'b1;
      @(negedge clk);
      idle_checks("rst_drain_post");
      req_valid = 1'b1; req_op = SYSOP_CSRS; req_pc = 64'h700; req_rd = 5'd6; pipe_busy = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rissue_op_pre", {59'b0, csr_op}, {59'b0, SYSOP_CSRS});
      csr_r_valid = 1'b1; csr_trap_en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      idle_checks("rst_issue");
      #1 rst_n = 1'b1;
      @(negedge clk);
      idle_checks("rst_issue_post");
      run_req(tbl[0]);
      for (int i = 0; i < 40; i++) begin
         v.op = 5'($urandom); v.pc = {$urandom, $urandom}; v.tval = {$urandom, $urandom};
         v.wdata = {$urandom, $urandom}; v.rd = 5'($urandom); v.nb = $urandom_range(0, 6);
         v.rdata = {$urandom, $urandom}; v.rv = 1'($urandom); v.te = 1'($urandom);
         v.tpc = {$urandom, $urandom};
         if (is_except(v.op)) begin
            v.rv = 1'b0;
            v.te = 1'b1;
         end
         run_req(v);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
